// File: rtl/pwd_candidate_gen_pkg.sv
// Shared definitions for the password candidate generator and its consumers.
// Holds the default charset size, the FSM state encoding and the index-to-ASCII map.
// charset_char is also used on the checker side to decode matched indices.
package pwd_candidate_gen_pkg;

  localparam int DEF_CHARSET_SIZE = 62;
  localparam int IDX_W            = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 0-25 -> 'a'-'z', 26-51 -> 'A'-'Z', 52-61 -> '0'-'9'
  function automatic logic [7:0] charset_char(input logic [IDX_W-1:0] idx);
    logic [7:0] i8;
    i8 = {2'b00, idx};
    if (idx < 6'd26)      return 8'h61 + i8;
    else if (idx < 6'd52) return 8'h41 + (i8 - 8'd26);
    else                  return 8'h30 + (i8 - 8'd52);
  endfunction

endpackage

// File: rtl/pwd_odometer.sv
// Purpose: combinational odometer step over MAX_LEN 6-bit indices; position len-1 is least significant.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to commit next_idx.
// Ports: idx (current indices, position p at [6p +: 6]), len (active positions),
//        next_idx (incremented indices), carry (wrap out of position 0).
module pwd_odometer
  import pwd_candidate_gen_pkg::*;
#(
  parameter int CHARSET_SIZE = DEF_CHARSET_SIZE,
  parameter int MAX_LEN      = 20
) (
  input  logic [IDX_W*MAX_LEN-1:0] idx,
  input  logic [7:0]               len,
  output logic [IDX_W*MAX_LEN-1:0] next_idx,
  output logic                     carry
);

  always_comb begin
    next_idx = idx;
    carry    = 1'b1;
    // Ripple from the rightmost active position toward position 0; inactive
    // positions beyond len are left untouched.
    for (int p = MAX_LEN - 1; p >= 0; p--) begin
      if ((p < int'(len)) && carry) begin
        if (idx[IDX_W*p +: IDX_W] == IDX_W'(CHARSET_SIZE - 1)) begin
          next_idx[IDX_W*p +: IDX_W] = '0;
        end else begin
          next_idx[IDX_W*p +: IDX_W] = idx[IDX_W*p +: IDX_W] + IDX_W'(1);
          carry = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/pwd_candidate_gen.sv
// Purpose: brute-force password candidate generator, odometer order from min_len to max_len characters.
// Latency: first candidate one cycle after start; one candidate per cycle while out_ready is high.
// Backpressure: valid/ready; passwd_chars/passwd_len hold stable while out_valid && !out_ready.
// Ports: clk, rst_n (async active-low); start/stop control; min_len/max_len range;
//        out_valid/out_ready handshake with passwd_chars (left-aligned bytes) and passwd_len;
//        busy (RUN), exhausted (DONE), count (saturating accepted-candidate count).
module pwd_candidate_gen
  import pwd_candidate_gen_pkg::*;
#(
  parameter int CHARSET_SIZE = DEF_CHARSET_SIZE,
  parameter int MAX_LEN      = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [4:0]           min_len,
  input  logic [4:0]           max_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*MAX_LEN-1:0] passwd_chars,
  output logic [7:0]           passwd_len,
  output logic                 busy,
  output logic                 exhausted,
  output logic [47:0]          count
);

  localparam int         IW        = IDX_W * MAX_LEN;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] next_idx;
  logic [7:0]    len_q;
  logic [7:0]    lim_q;
  logic          carry;

  logic [7:0]    min_eff, max_eff, len_inc;
  logic          range_empty, hs, past_end;

  // Length sanitising: zero min means one, max clamps to the vector capacity.
  assign min_eff     = (min_len == 5'd0) ? 8'd1 : {3'b000, min_len};
  assign max_eff     = ({3'b000, max_len} > MAX_LEN_B) ? MAX_LEN_B : {3'b000, max_len};
  assign range_empty = (min_eff > max_eff);

  assign hs       = out_valid && out_ready;
  assign len_inc  = len_q + 8'd1;
  // The accepted candidate was the last one of the whole range.
  assign past_end = carry && (len_inc > lim_q);

  pwd_odometer #(
    .CHARSET_SIZE (CHARSET_SIZE),
    .MAX_LEN      (MAX_LEN)
  ) u_odometer (
    .idx      (idx_q),
    .len      (len_q),
    .next_idx (next_idx),
    .carry    (carry)
  );

  // Left-aligned byte image: position 0 in the top byte, unused bytes zero.
  function automatic logic [8*MAX_LEN-1:0] encode(input logic [IW-1:0] ix,
                                                   input logic [7:0]    ln);
    logic [8*MAX_LEN-1:0] v;
    v = '0;
    for (int p = 0; p < MAX_LEN; p++) begin
      if (p < int'(ln)) v[8*(MAX_LEN-1-p) +: 8] = charset_char(ix[IDX_W*p +: IDX_W]);
    end
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = range_empty ? ST_DONE : ST_RUN;
        ST_RUN:           if (hs && past_end) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      lim_q        <= '0;
      out_valid    <= 1'b0;
      passwd_chars <= '0;
      passwd_len   <= '0;
      busy         <= 1'b0;
      exhausted    <= 1'b0;
      count        <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d == ST_RUN);
      exhausted <= (state_d == ST_DONE);
      if (stop) begin
        // Abort discards whatever candidate was on offer.
        out_valid    <= 1'b0;
        passwd_chars <= '0;
        passwd_len   <= '0;
      end else if (state_q != ST_RUN) begin
        if (start) begin
          count <= '0;
          idx_q <= '0;
          len_q <= min_eff;
          lim_q <= max_eff;
          if (!range_empty) begin
            out_valid    <= 1'b1;
            passwd_chars <= encode('0, min_eff);
            passwd_len   <= min_eff;
          end
        end
      end else if (hs) begin
        if (count != '1) count <= count + 48'd1;
        if (past_end) begin
          out_valid <= 1'b0;
        end else if (carry) begin
          // Length roll-over: restart at all 'a' one character longer.
          idx_q        <= '0;
          len_q        <= len_inc;
          passwd_chars <= encode('0, len_inc);
          passwd_len   <= len_inc;
        end else begin
          idx_q        <= next_idx;
          passwd_chars <= encode(next_idx, len_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwd_candidate_gen.sv
module tb_pwd_candidate_gen;

  typedef struct {
    logic [159:0] c;
    logic [7:0]   l;
  } cand_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [4:0]   min_len = 5'd0;
  logic [4:0]   max_len = 5'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [159:0] passwd_chars;
  logic [7:0]   passwd_len;
  logic         busy;
  logic         exhausted;
  logic [47:0]  count;

  int    checks = 0;
  int    passes = 0;
  bit    mon_en = 1'b0;
  cand_t exp_q[$];

  pwd_candidate_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .min_len      (min_len),
    .max_len      (max_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .passwd_chars (passwd_chars),
    .passwd_len   (passwd_len),
    .busy         (busy),
    .exhausted    (exhausted),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: candidate k of length L as base-62 digits, last char least significant.
  function automatic logic [159:0] model(input int L, input longint k);
    string        cs;
    logic [159:0] v;
    longint       r;
    cs = "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    v  = '0;
    r  = k;
    for (int p = L - 1; p >= 0; p--) begin
      v[159-8*p -: 8] = cs[int'(r % 62)];
      r = r / 62;
    end
    return v;
  endfunction

  task automatic push_range(input int lo, input int hi);
    cand_t e;
    for (int L = lo; L <= hi; L++) begin
      longint n = 1;
      for (int i = 0; i < L; i++) n = n * 62;
      for (longint k = 0; k < n; k++) begin
        e.c = model(L, k);
        e.l = 8'(L);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: a handshake will occur at the next rising edge; pop and compare.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_candidate: got %h len %0d expected none", passwd_chars, passwd_len);
      end else begin
        cand_t e;
        e = exp_q.pop_front();
        chk("cand_chars", passwd_chars, e.c);
        chk("cand_len", passwd_len, e.l);
      end
    end
  end

  task automatic do_start(input logic [4:0] lo, input logic [4:0] hi);
    @(posedge clk); #1;
    min_len = lo;
    max_len = hi;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic do_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic wait_count(input longint k, input int budget, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      if (count == 48'(k)) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk(nm, hit, 1'b1);
  endtask

  task automatic wait_exhausted(input int budget, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #1;
      if (exhausted) hit = 1'b1;
    end
    chk(nm, hit, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] snap;
    logic [159:0] all_a;
    all_a = {20{8'h61}};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_exhausted", exhausted, 1'b0);
    chk("rst_count", count, 48'd0);
    chk("rst_chars", passwd_chars, 160'd0);
    chk("rst_len", passwd_len, 8'd0);
    rst_n = 1'b1;

    // min=max=1: 62 single-char candidates
    push_range(1, 1);
    mon_en    = 1'b1;
    out_ready = 1'b1;
    do_start(5'd1, 5'd1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_first", passwd_chars[159:152], 8'h61);
    wait_count(61, 200, "t1_reach61");
    chk("t1_last", passwd_chars[159:152], 8'h39);
    wait_exhausted(10, "t1_done");
    chk("t1_count", count, 48'd62);
    chk("t1_valid_off", out_valid, 1'b0);
    chk("t1_busy_off", busy, 1'b0);
    chk("t1_queue_empty", exp_q.size(), 0);

    // min=1, max=2: roll-over into length 2, 3906 total
    push_range(1, 2);
    do_start(5'd1, 5'd2);
    wait_count(62, 200, "t2_reach62");
    chk("t2_len2", passwd_len, 8'd2);
    chk("t2_aa", passwd_chars[159:144], 16'h6161);
    chk("t2_rest0", passwd_chars[143:0], 144'd0);
    wait_exhausted(5000, "t2_done");
    chk("t2_count", count, 48'd3906);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Backpressure mid-run, min=max=2
    push_range(2, 2);
    do_start(5'd2, 5'd2);
    wait_count(100, 300, "t4_reach100");
    out_ready = 1'b0;
    snap = passwd_chars;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_chars_hold", passwd_chars, snap);
      chk("bp_len_hold", passwd_len, 8'd2);
      chk("bp_count_hold", count, 48'd100);
      chk("bp_valid_hold", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    wait_exhausted(5000, "t4_done");
    chk("t4_count", count, 48'd3844);
    chk("t4_queue_empty", exp_q.size(), 0);

    // min=max=20 and clamped max=25: identical first candidate
    mon_en    = 1'b0;
    out_ready = 1'b0;
    do_start(5'd20, 5'd20);
    chk("t3_chars20", passwd_chars, all_a);
    chk("t3_len20", passwd_len, 8'd20);
    do_stop();
    chk("t3_stop_valid", out_valid, 1'b0);
    do_start(5'd20, 5'd25);
    chk("t3_clamp_chars", passwd_chars, all_a);
    chk("t3_clamp_len", passwd_len, 8'd20);
    chk("t3_clamp_busy", busy, 1'b1);
    do_stop();

    // min=0 behaves as 1
    do_start(5'd0, 5'd3);
    chk("t5_min0_len", passwd_len, 8'd1);
    chk("t5_min0_char", passwd_chars[159:152], 8'h61);
    do_stop();

    // Empty range: min=3 > max=2
    out_ready = 1'b1;
    do_start(5'd3, 5'd2);
    chk("t6_exhausted", exhausted, 1'b1);
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_count", count, 48'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("t6_valid_stays0", out_valid, 1'b0);
    end

    // stop together with start mid-run
    do_start(5'd2, 5'd2);
    repeat (5) @(posedge clk);
    #1;
    stop  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    stop  = 1'b0;
    start = 1'b0;
    chk("t7_valid", out_valid, 1'b0);
    chk("t7_busy", busy, 1'b0);
    chk("t7_exhausted", exhausted, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t7_still_idle", out_valid, 1'b0);

    // Asynchronous reset mid-run
    do_start(5'd3, 5'd3);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t8_valid", out_valid, 1'b0);
    chk("t8_busy", busy, 1'b0);
    chk("t8_count", count, 48'd0);
    chk("t8_chars", passwd_chars, 160'd0);
    chk("t8_len", passwd_len, 8'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t8_no_emit", out_valid, 1'b0);
    chk("t8_idle_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pwd_candidate_gen.md
# pwd_candidate_gen

Brute-force password candidate generator feeding the NTLM encode / `md4block` stage. Enumerates every string over a fixed 62-symbol charset in odometer order, from `min_len` to `max_len` characters. Presents each candidate as a left-aligned 160-bit byte vector plus a length, in the same format `password_to_md4_data` consumes. Uses a valid/ready handshake, so the MD4 stage can apply backpressure.

## Interface
- `CHARSET_SIZE`, default 62: number of symbols; indices 0..CHARSET_SIZE-1.
- `MAX_LEN`, default 20: maximum password length in characters; sets the output vector width of 8*MAX_LEN.
- `clk`  in  1: rising-edge clock (single clock; already decided).
- `rst_n`  in  1: reset, asynchronous and active-low (already decided).
- `start`  in  1: single-cycle pulse that begins a new enumeration.
- `stop`  in  1: abort the current enumeration.
- `min_len`  in  5: first length to enumerate.
- `max_len`  in  5: last length to enumerate.
- `out_valid`  out  1: candidate on `passwd_chars`/`passwd_len` is valid.
- `out_ready`  in  1: downstream accepts the candidate.
- `passwd_chars`  out  160: first char at [159:152]; unused trailing bytes are 8'h00.
- `passwd_len`  out  8: candidate length in characters.
- `busy`  out  1: high in RUN.
- `exhausted`  out  1: high in DONE.
- `count`  out  48: number of candidates accepted since the last `start`.

## Operation
- FSM states:
  - IDLE: waits for `start`.
  - RUN: enumerating.
  - DONE: enumeration finished; holds until `start` or `stop`.
- Length sanitising, applied at `start`:
  - `min_len`==0 is treated as 1.
  - `max_len`>MAX_LEN is clamped to MAX_LEN.
  - If effective min > effective max, go directly to DONE with no candidates.
- State per position: index register, 6 bits × MAX_LEN. Char byte = `charset_char(index)`:
  - 0–25 → 'a'–'z'
  - 26–51 → 'A'–'Z'
  - 52–61 → '0'–'9'
- Increment on each handshake (`out_valid && out_ready`):
  - The rightmost active position (len-1) increments.
  - Wrap from CHARSET_SIZE-1 to 0 carries left; ripple is combinational across positions.
  - Carry out of position 0: len increments and all indices clear to 0.
  - If the new len exceeds max: go to DONE.
- `count` increments by 1 on every handshake. It saturates at all-ones and does not wrap.
- `start` is honoured in IDLE and DONE and ignored in RUN. It clears `count`.
- `stop` in any state → IDLE next cycle, `out_valid` drops, and any pending candidate is discarded. `stop` wins over a simultaneous `start`.

## Timing
- Reset values:
  - `out_valid`=0, `busy`=0, `exhausted`=0, `count`=0.
  - `passwd_chars`=0, `passwd_len`=0.
  - FSM=IDLE.
- `start` in cycle N → `busy`=1 and `out_valid`=1 with the first candidate (min_len × 'a') in cycle N+1.
- All outputs are registered. `passwd_chars`/`passwd_len` must be held stable while `out_valid && !out_ready`.
- Throughput is one candidate per cycle while `out_ready`=1. The next candidate appears the cycle after the handshake.
- Handshake on the last candidate in cycle M → in M+1: `out_valid`=0, `busy`=0, `exhausted`=1, and `count` is final.
- Empty range: `start` in N → `exhausted`=1 in N+1 and `out_valid` never asserts.
- `rst_n` deassertion mid-RUN: immediate return to reset values. No candidate is emitted until a new `start`.

## Structure
- Shared include `src/inc/charset.v` holds:
  - `CHARSET_SIZE` constant
  - `charset_char(idx)` function
  - state encodings IDLE/RUN/DONE
- The `hashchecker`/testbench side also uses `charset_char` for decoding matches.
- One sub-module is natural: `pwd_odometer`, a combinational increment and carry ripple over MAX_LEN 6-bit indices. It outputs the next indices and a carry-out.
- FSM, length registers, output registers and `count` live in `pwd_candidate_gen`.

## Test plan
- min=max=1, `out_ready`=1 → 62 candidates; first `passwd_chars[159:152]`=8'h61, last 8'h39. `exhausted`=1 the cycle after the 62nd handshake; `count`=62.
- min=1, max=2 → candidate 63 is len 2 with `passwd_chars[159:144]`=16'h6161 and rest 0. Total `count`=3906.
- min=max=20 → first `passwd_chars`={20{8'h61}}, `passwd_len`=20. `max_len`=25 gives an identical first candidate (clamp).
- Backpressure: `out_ready`=0 for 5 cycles mid-run → outputs frozen and `count` unchanged. Resume yields the next candidate in sequence with no skip or duplicate.
- min=3, max=2 → `exhausted`=1 one cycle after `start`; `out_valid` stays 0; `count`=0.
- `stop` and `start` asserted together mid-run → IDLE, `out_valid`=0 next cycle. `rst_n` low mid-run → all outputs 0 asynchronously.
